// File: rtl/aes_pkg.sv
// Shared AES primitives for the iterative encrypt/decrypt cores: S-box tables, xtime,
// the 16-byte state type and the round-engine FSM encoding.
package aes_pkg;

    localparam int NR_128 = 10;
    localparam int NR_192 = 12;
    localparam int NR_256 = 14;

    // Element 15 holds FIPS-197 byte 0, so a state_t maps bit-for-bit onto a 128-bit block.
    typedef logic [15:0][7:0] state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_FLAT[(255 - int'(b)) * 8 +: 8];
    endfunction

    // The inverse is derived from the forward table so the two can never disagree.
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 256; i++) begin
            if (sbox(8'(i)) == b) r = 8'(i);
        end
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, MixColumns (skipped when
// last is high) and AddRoundKey.
module aes_enc_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         last,
    output logic [127:0] state_out
);

    state_t w_in;
    state_t w_sub;
    state_t w_shift;
    state_t w_mix;

    assign w_in = state_in;

    // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_bytes
            localparam int ROW = gi % 4;
            localparam int COL = gi / 4;
            localparam int SRC = ROW + 4 * ((COL + ROW) % 4);
            assign w_sub[15-gi]   = sbox(w_in[15-gi]);
            assign w_shift[15-gi] = w_sub[15-SRC];
        end

        for (genvar gi = 0; gi < 4; gi++) begin : g_cols
            logic [7:0] w_a0, w_a1, w_a2, w_a3;
            assign w_a0 = w_shift[15-4*gi];
            assign w_a1 = w_shift[14-4*gi];
            assign w_a2 = w_shift[13-4*gi];
            assign w_a3 = w_shift[12-4*gi];
            assign w_mix[15-4*gi] = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
            assign w_mix[14-4*gi] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
            assign w_mix[13-4*gi] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
            assign w_mix[12-4*gi] = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
        end
    endgenerate

    assign state_out = (last ? w_shift : w_mix) ^ round_key;

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES encryptor, one round per clock, valid/ready on both sides.
// Optional AES_ENC_ABORT_EN adds an `abort` input that drops the block in flight.
module aes_encrypt_iter
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [(Nr+1)*128-1:0] all_keys,
    input  logic [127:0]          in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [127:0]          out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
`ifdef AES_ENC_ABORT_EN
    input  logic                  abort,
`endif
    output logic                  busy
);

    generate
        if (Nr != Nk + 6 || (Nk != 4 && Nk != 6 && Nk != 8)) begin : g_cfg_err
            $error("aes_encrypt_iter: Nk must be 4/6/8 and Nr must equal Nk+6");
        end
    endgenerate

    fsm_t         r_fsm;
    logic [3:0]   r_round;
    logic [127:0] r_state;
    logic         r_in_ready;
    logic         r_busy;
    logic         r_out_valid;

    logic [Nr:0][127:0] w_keys;
    logic [127:0]       w_round_out;
    logic               w_last;
    logic               w_abort;

`ifdef AES_ENC_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // w_keys[r] is round key r; key 0 occupies the most significant slice of all_keys.
    generate
        for (genvar gi = 0; gi <= Nr; gi++) begin : g_keys
            assign w_keys[gi] = all_keys[(Nr-gi)*128 +: 128];
        end
    endgenerate

    assign w_last = (r_round == 4'(Nr));

    aes_enc_round u_round (
        .state_in  (r_state),
        .round_key (w_keys[r_round]),
        .last      (w_last),
        .state_out (w_round_out)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fsm       <= IDLE;
            r_round     <= 4'd0;
            r_state     <= '0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_abort && r_fsm != IDLE) begin
            r_fsm       <= IDLE;
            r_round     <= 4'd0;
            r_state     <= '0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    // An abort in IDLE changes nothing except that it blocks this accept.
                    if (in_valid && r_in_ready && !w_abort) begin
                        r_state    <= in_data ^ w_keys[0];
                        r_round    <= 4'd1;
                        r_fsm      <= RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                RUN: begin
                    r_state <= w_round_out;
                    if (w_last) begin
                        r_fsm       <= DONE;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_round <= r_round + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_fsm       <= IDLE;
                        r_round     <= 4'd0;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_fsm       <= IDLE;
                    r_round     <= 4'd0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign out_data  = r_state;

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Self-checking bench for aes_encrypt_iter: FIPS-197 vectors for all three key sizes,
// output hold, back-to-back issue, mid-block reset and (with AES_ENC_ABORT_EN) abort.
module tb_aes_encrypt_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [1407:0] keys4;
    logic [1663:0] keys6;
    logic [1919:0] keys8;
    logic [127:0]  din;
    logic          iv4, iv6, iv8, ordy, ordy68, abort_in, abort_off;
    logic          rdy4, rdy6, rdy8, ov4, ov6, ov8, busy4, busy6, busy8;
    logic [127:0]  od4, od6, od8;

    int checks = 0;
    int errors = 0;
    logic [127:0] sb_q[$];

    localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT2_192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT2_256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT3 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT3 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KF   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};

    aes_encrypt_iter #(.Nk(4), .Nr(10)) u_dut4 (
        .clk(clk), .reset_n(rst_n), .all_keys(keys4), .in_data(din), .in_valid(iv4),
        .in_ready(rdy4), .out_data(od4), .out_valid(ov4), .out_ready(ordy),
`ifdef AES_ENC_ABORT_EN
        .abort(abort_in),
`endif
        .busy(busy4)
    );

    aes_encrypt_iter #(.Nk(6), .Nr(12)) u_dut6 (
        .clk(clk), .reset_n(rst_n), .all_keys(keys6), .in_data(din), .in_valid(iv6),
        .in_ready(rdy6), .out_data(od6), .out_valid(ov6), .out_ready(ordy68),
`ifdef AES_ENC_ABORT_EN
        .abort(abort_off),
`endif
        .busy(busy6)
    );

    aes_encrypt_iter #(.Nk(8), .Nr(14)) u_dut8 (
        .clk(clk), .reset_n(rst_n), .all_keys(keys8), .in_data(din), .in_valid(iv8),
        .in_ready(rdy8), .out_data(od8), .out_valid(ov8), .out_ready(ordy68),
`ifdef AES_ENC_ABORT_EN
        .abort(abort_off),
`endif
        .busy(busy8)
    );

    // Reference key schedule, with the S-box computed from GF(2^8) inversion plus affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic hi;
        a = a_in; b = b_in; p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] ref_sbox(input logic [7:0] b);
        logic [7:0] inv;
        inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (gmul(b, 8'(y)) == 8'h01) inv = 8'(y);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {ref_sbox(w[31:24]), ref_sbox(w[23:16]), ref_sbox(w[15:8]), ref_sbox(w[7:0])};
    endfunction

    function automatic logic [1919:0] expand_key(input logic [255:0] key, input int nk);
        logic [31:0]   w [60];
        logic [31:0]   temp;
        logic [7:0]    rcon;
        logic [1919:0] res;
        int total;
        total = 4 * (nk + 7);
        rcon = 8'h01;
        res = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < total; i++) begin
            temp = w[i-1];
            if (i % nk == 0) begin
                temp = sub_word({temp[23:0], temp[31:24]}) ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                temp = sub_word(temp);
            end
            w[i] = w[i-nk] ^ temp;
        end
        for (int i = 0; i < total; i++) res[1919 - 32*i -: 32] = w[i];
        return res;
    endfunction

    task automatic load_keys4(input logic [255:0] key);
        logic [1919:0] kx;
        kx = expand_key(key, 4);
        keys4 = kx[1919 -: 1408];
    endtask

    task automatic accept4(input logic [127:0] pt, input logic [127:0] ct, input logic [255:0] key);
        load_keys4(key);
        din = pt;
        iv4 = 1'b1;
        checks++;
        if (rdy4 !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready: in_ready=%b expected 1", rdy4);
        end
        @(posedge clk); #1;
        iv4 = 1'b0;
        sb_q.push_back(ct);
    endtask

    task automatic wait_out4(input int exp_lat, input string name);
        int lat;
        logic [127:0] exp;
        lat = 0;
        while (ov4 !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d clocks expected %0d", name, lat, exp_lat);
        end
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s_scoreboard: output with no expected entry, got %h", name, od4);
        end else begin
            exp = sb_q.pop_front();
            if (od4 !== exp) begin
                errors++;
                $display("FAIL %s_data: got %h expected %h", name, od4, exp);
            end
        end
        $display("txn %s: out_data=%h latency=%0d", name, od4, lat);
    endtask

    task automatic consume4();
        ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0;
        checks++;
        if (rdy4 !== 1'b1 || ov4 !== 1'b0) begin
            errors++;
            $display("FAIL handshake: in_ready=%b out_valid=%b expected 1/0", rdy4, ov4);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rdy4 !== 1'b1 || busy4 !== 1'b0 || ov4 !== 1'b0 || od4 !== 128'h0) begin
            errors++;
            $display("FAIL reset4: rdy=%b busy=%b ov=%b od=%h expected 1/0/0/0", rdy4, busy4, ov4, od4);
        end
        checks++;
        if (rdy6 !== 1'b1 || ov6 !== 1'b0 || od6 !== 128'h0 || rdy8 !== 1'b1 || ov8 !== 1'b0 || od8 !== 128'h0) begin
            errors++;
            $display("FAIL reset68: rdy6=%b ov6=%b rdy8=%b ov8=%b expected 1/0/1/0", rdy6, ov6, rdy8, ov8);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("txn reset: released");
    endtask

    task automatic test_fips128();
        accept4(PT1, CT1, K128);
        checks++;
        if (busy4 !== 1'b1 || rdy4 !== 1'b0) begin
            errors++;
            $display("FAIL run_flags: busy=%b in_ready=%b expected 1/0", busy4, rdy4);
        end
        wait_out4(10, "fips128");
        checks++;
        if (busy4 !== 1'b0 || rdy4 !== 1'b0) begin
            errors++;
            $display("FAIL done_flags: busy=%b in_ready=%b expected 0/0", busy4, rdy4);
        end
        consume4();
    endtask

    task automatic test_key_sizes();
        logic [1919:0] kx;
        int lat;
        for (int n = 0; n < 2; n++) begin
            din = PT1;
            if (n == 0) begin
                kx = expand_key(K192, 6);
                keys6 = kx[1919 -: 1664];
                iv6 = 1'b1;
                sb_q.push_back(CT2_192);
            end else begin
                kx = expand_key(K256, 8);
                keys8 = kx;
                iv8 = 1'b1;
                sb_q.push_back(CT2_256);
            end
            @(posedge clk); #1;
            iv6 = 1'b0;
            iv8 = 1'b0;
            lat = 0;
            while (((n == 0) ? ov6 : ov8) !== 1'b1 && lat < 40) begin
                @(posedge clk); #1;
                lat++;
            end
            checks++;
            if (lat != 12 + 2*n) begin
                errors++;
                $display("FAIL nk%0d_latency: got %0d clocks expected %0d", 6 + 2*n, lat, 12 + 2*n);
            end
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL nk%0d_scoreboard: empty queue", 6 + 2*n);
            end else if (((n == 0) ? od6 : od8) !== sb_q[0]) begin
                errors++;
                $display("FAIL nk%0d_data: got %h expected %h", 6 + 2*n, (n == 0) ? od6 : od8, sb_q[0]);
            end
            if (sb_q.size() != 0) void'(sb_q.pop_front());
            $display("txn nk%0d: out_data=%h latency=%0d", 6 + 2*n, (n == 0) ? od6 : od8, lat);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_hold();
        accept4(PT3, CT3, KF);
        wait_out4(10, "fips_appb");
        for (int c = 0; c < 5; c++) begin
            din = {$urandom, $urandom, $urandom, $urandom};
            iv4 = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (ov4 !== 1'b1 || od4 !== CT3 || rdy4 !== 1'b0 || busy4 !== 1'b0) begin
                errors++;
                $display("FAIL hold_c%0d: ov=%b od=%h rdy=%b busy=%b expected 1/%h/0/0", c, ov4, od4, rdy4, busy4, CT3);
            end
        end
        iv4 = 1'b0;
        $display("txn hold: output held 5 clocks");
        consume4();
    endtask

    task automatic test_back_to_back();
        int cyc, n_acc, n_out;
        int acc_cyc[2];
        logic [127:0] exp;
        load_keys4(K128);
        din = PT1;
        ordy = 1'b1;
        iv4 = 1'b1;
        cyc = 0; n_acc = 0; n_out = 0;
        acc_cyc[0] = 0; acc_cyc[1] = 0;
        while (n_out < 2 && cyc < 80) begin
            if (rdy4 === 1'b1 && iv4 === 1'b1 && n_acc < 2) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                sb_q.push_back((n_acc == 1) ? CT1 : CT3);
            end
            @(posedge clk); #1;
            cyc++;
            if (ov4 === 1'b1) begin
                checks++;
                exp = (sb_q.size() != 0) ? sb_q.pop_front() : 128'hx;
                if (od4 !== exp) begin
                    errors++;
                    $display("FAIL b2b_data%0d: got %h expected %h", n_out, od4, exp);
                end
                $display("txn b2b%0d: out_data=%h cycle=%0d", n_out, od4, cyc);
                n_out++;
                if (n_out == 1) begin
                    din = PT3;
                    load_keys4(KF);
                end else begin
                    iv4 = 1'b0;
                end
            end
        end
        checks++;
        if (n_out != 2 || n_acc != 2 || acc_cyc[1] - acc_cyc[0] != 12) begin
            errors++;
            $display("FAIL b2b_spacing: outs=%0d accepts=%0d spacing=%0d expected 2/2/12",
                     n_out, n_acc, acc_cyc[1] - acc_cyc[0]);
        end
        iv4 = 1'b0;
        @(posedge clk); #1;
        ordy = 1'b0;
        checks++;
        if (rdy4 !== 1'b1 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_idle: in_ready=%b queue=%0d expected 1/0", rdy4, sb_q.size());
        end
    endtask

    task automatic test_reset_mid();
        accept4(PT1, CT1, K128);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rdy4 !== 1'b1 || busy4 !== 1'b0 || ov4 !== 1'b0 || od4 !== 128'h0) begin
            errors++;
            $display("FAIL midreset: rdy=%b busy=%b ov=%b od=%h expected 1/0/0/0", rdy4, busy4, ov4, od4);
        end
        sb_q.delete();
        $display("txn midreset: block abandoned");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        accept4(PT3, CT3, KF);
        wait_out4(10, "after_reset");
        consume4();
    endtask

`ifdef AES_ENC_ABORT_EN
    task automatic test_abort();
        int seen;
        accept4(PT1, CT1, K128);
        repeat (2) @(posedge clk);
        #1;
        abort_in = 1'b1;
        @(posedge clk); #1;
        abort_in = 1'b0;
        checks++;
        if (rdy4 !== 1'b1 || busy4 !== 1'b0 || ov4 !== 1'b0 || od4 !== 128'h0) begin
            errors++;
            $display("FAIL abort_run: rdy=%b busy=%b ov=%b od=%h expected 1/0/0/0", rdy4, busy4, ov4, od4);
        end
        sb_q.delete();
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (ov4 === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_no_valid: out_valid seen %0d times expected 0", seen);
        end
        din = PT3;
        iv4 = 1'b1;
        abort_in = 1'b1;
        @(posedge clk); #1;
        abort_in = 1'b0;
        iv4 = 1'b0;
        checks++;
        if (rdy4 !== 1'b1 || busy4 !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: rdy=%b busy=%b expected 1/0", rdy4, busy4);
        end
        $display("txn abort: block dropped");
        accept4(PT3, CT3, KF);
        wait_out4(10, "after_abort");
        consume4();
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        keys4 = '0; keys6 = '0; keys8 = '0;
        din = '0;
        iv4 = 1'b0; iv6 = 1'b0; iv8 = 1'b0;
        ordy = 1'b0; ordy68 = 1'b1;
        abort_in = 1'b0; abort_off = 1'b0;

        test_reset();
        test_fips128();
        test_key_sizes();
        test_hold();
        test_back_to_back();
        test_reset_mid();
`ifdef AES_ENC_ABORT_EN
        test_abort();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
